// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encoding used by serial_adder_ctrl.
package serial_adder_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Reused unchanged by the serial adder as its only arithmetic element.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c_in;
    assign carry = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder reused once per clock, LSB first.
// start/busy/done handshake; result held until the next add completes.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH > 1 ? WIDTH : 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   s_next;
    logic               last;

    full_adder u_fa (a_sh_q[0], b_sh_q[0], carry_q, fa_s, fa_co);

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    // Partial-sum shifter; bit 0 would only ever be shifted out,
    // so only the upper WIDTH-1 bits are stored.
    if (WIDTH > 1) begin : g_sh
        logic [WIDTH-2:0] s_sh_q;

        assign s_next = {fa_s, s_sh_q};

        // Collect one sum bit per RUN cycle, entering at the MSB.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_sh_q <= '0;
            end else if (state_q == ST_RUN) begin
                s_sh_q <= s_next[WIDTH-1:1];
            end
        end
    end else begin : g_nosh
        assign s_next = fa_s;
    end

    // Next-state: capture operands on start, shift while running,
    // publish the result on the final bit.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) begin
                    sum_d   = s_next;
                    cout_d  = fa_co;
                    // Parked at zero so a 1-bit build never leaves 0.
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand, carry, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign c_out = cout_q;

endmodule
